// File: rtl/fb_sdram_arbiter.sv
// Two-port burst arbiter sharing one Avalon-MM SDRAM slave between the VGA fetcher (port 0) and the blitter (port 1).
// Optional starvation guard for port 1 is enabled by defining FB_ARB_STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | arbitrate; in the registered grant cycle, launch the latched burst
// RD_CMD  | av_read asserted until the slave drops waitrequest
// RD_DATA | forward readdatavalid beats to the granted port until the last one
// WR_DATA | stream blitter write beats, paced by waitrequest
module fb_sdram_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 4,
   parameter int STARVE_MAX = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [LEN_W-1:0]  p0_len,
   output logic              p0_grant,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_rvalid,
   output logic              p0_done,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [LEN_W-1:0]  p1_len,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_wready,
   output logic              p1_grant,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_rvalid,
   output logic              p1_done,
   output logic [ADDR_W-1:0] av_address,
   output logic              av_read,
   output logic              av_write,
   output logic [LEN_W:0]    av_burstcount,
   output logic [DATA_W-1:0] av_writedata,
   input  logic              av_waitrequest,
   input  logic [DATA_W-1:0] av_readdata,
   input  logic              av_readdatavalid
);

   typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_DATA} state_t;

   state_t              state, state_nx;
   logic                grant0_q, grant1_q;
   logic                sel_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W:0]      cnt_q;

   logic arb, win0, win1, force1;
   logic rd_beat, wr_acc, last, cmd_phase;

   `ifdef FB_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_q;

   always_ff @(posedge clk) begin
      if (reset)
         starve_q <= '0;
      else if (grant1_q)
         starve_q <= '0;
      else if (p1_req && (starve_q != SW'(STARVE_MAX)))
         starve_q <= starve_q + SW'(1);
   end

   assign force1 = (starve_q == SW'(STARVE_MAX));
   `else
   assign force1 = 1'b0;
   `endif

   // The grant cycle itself is spent in IDLE, so arbitration pauses while a grant is pending.
   assign arb  = (state == IDLE) && !grant0_q && !grant1_q;
   assign win1 = p1_req && (!p0_req || force1);
   assign win0 = p0_req && !win1;

   assign last      = (cnt_q == {1'b0, len_q});
   assign rd_beat   = (state == RD_DATA) && av_readdatavalid;
   assign wr_acc    = (state == WR_DATA) && !av_waitrequest;
   assign cmd_phase = ((state == RD_CMD) || (state == WR_DATA)) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         sel_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state    <= state_nx;
         grant0_q <= arb && win0;
         grant1_q <= arb && win1;
         if (arb && (win0 || win1)) begin
            sel_q  <= win1;
            we_q   <= win1 && p1_we;
            addr_q <= win1 ? p1_addr : p0_addr;
            len_q  <= win1 ? p1_len : p0_len;
            cnt_q  <= '0;
         end else if (rd_beat || wr_acc) begin
            cnt_q  <= cnt_q + (LEN_W+1)'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant0_q || grant1_q) state_nx = we_q ? WR_DATA : RD_CMD;
         RD_CMD:  if (!av_waitrequest) state_nx = RD_DATA;
         RD_DATA: if (rd_beat && last) state_nx = IDLE;
         WR_DATA: if (wr_acc && last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign p0_grant = grant0_q;
   assign p1_grant = grant1_q;

   assign av_read       = cmd_phase && (state == RD_CMD);
   assign av_write      = cmd_phase && (state == WR_DATA);
   assign av_address    = cmd_phase ? addr_q : '0;
   assign av_burstcount = cmd_phase ? ({1'b0, len_q} + (LEN_W+1)'(1)) : '0;
   assign av_writedata  = av_write ? p1_wdata : '0;

   assign p0_rvalid = rd_beat && !sel_q;
   assign p1_rvalid = rd_beat && sel_q;
   assign p0_rdata  = p0_rvalid ? av_readdata : '0;
   assign p1_rdata  = p1_rvalid ? av_readdata : '0;
   assign p0_done   = p0_rvalid && last;
   assign p1_done   = (p1_rvalid && last) || (wr_acc && last);
   assign p1_wready = wr_acc;

endmodule

// File: doc/fb_sdram_arbiter.md
# fb_sdram_arbiter

Two-port arbiter that shares the SDRAM controller's single Avalon-MM slave between the VGA scanline fetcher (port 0, read-only, deadline-critical) and the sprite blitter (port 1, read/write). It sits between those two masters and the SDRAM controller inside the SoC fabric. It grants whole bursts, routes read data back to the granted port and paces write beats against `waitrequest`.

## Interface
Parameters:
- `ADDR_W`, 25: word address width.
- `DATA_W`, 16: data width (SDRAM DQ).
- `LEN_W`, 4: burst-length field width; the burst has `len+1` beats (1..16).
- `STARVE_MAX`, 64: port-1 wait cycles before a forced grant.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `p0_req` in 1: port-0 read request; hold until `p0_grant`.
- `p0_addr` in ADDR_W: burst start address.
- `p0_len` in LEN_W: beats minus one.
- `p0_grant` out 1: one-cycle pulse when the burst is accepted.
- `p0_rdata` out DATA_W: read beat.
- `p0_rvalid` out 1: `p0_rdata` valid.
- `p0_done` out 1: one-cycle pulse on the last beat.
- `p1_req`, `p1_we`, `p1_addr`, `p1_len` in: as port 0, plus `p1_we` (1 = write).
- `p1_wdata` in DATA_W: current write beat.
- `p1_wready` out 1: current write beat consumed this cycle.
- `p1_grant`, `p1_rdata`, `p1_rvalid`, `p1_done` out: as port 0.
- `av_address` out ADDR_W, `av_read` out 1, `av_write` out 1, `av_burstcount` out LEN_W+1, `av_writedata` out DATA_W: Avalon command.
- `av_waitrequest` in 1, `av_readdata` in DATA_W, `av_readdatavalid` in 1: Avalon response.

## Operation
- FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA.
- **IDLE**
  - Sample requests.
  - Priority: port 0 over port 1, except in the forced-grant case (see Configuration).
  - Latch the winner's addr, len and we.
  - Pulse its grant.
  - Go to RD_CMD (read) or WR_DATA (write).
  - No request: stay in IDLE.
  - Dropping a request before its grant is legal (the request is withdrawn).
- **RD_CMD**
  - `av_read` = 1, `av_burstcount` = len+1.
  - Hold while `av_waitrequest`.
  - Go to RD_DATA on the cycle `av_waitrequest` = 0.
- **RD_DATA**
  - Each `av_readdatavalid` is forwarded to the granted port's rdata/rvalid, and the beat counter increments.
  - When the counter reaches len: pulse done with the last rvalid, then go to IDLE.
- **WR_DATA**
  - `av_write` = 1, `av_writedata` = `p1_wdata`.
  - `av_address` and `av_burstcount` are driven on every beat.
  - `p1_wready` = `!av_waitrequest`.
  - On each accepted beat the counter increments and the blitter presents the next word on the following cycle.
  - After beat len+1 is accepted: pulse done, then go to IDLE.
- `av_readdatavalid` is ignored outside RD_DATA; no rvalid is generated.
- `rdata` is unregistered pass-through; rvalid is gated to the granted port only.

## Timing
- Reset values:
  - FSM in IDLE; beat counter and starvation counter at 0.
  - Every output 0, including all Avalon outputs, grants, rvalid, done and `p1_wready`.
- Request to grant: the grant is registered, 1 cycle after `req` is sampled in IDLE.
- `av_read`/`av_write` are asserted in the cycle after the grant.
- Read data latency: the SDRAM latency plus 0 cycles (combinational forward).
- Burst turnaround: the done cycle returns to IDLE, and arbitration happens the next cycle (minimum 1 idle cycle between bursts).
- Both ports requesting in IDLE: port 0 wins, unless the forced-grant flag is set.
- `len` = 0 means a single beat; `len` = 15 means 16 beats, `av_burstcount` = 16.
- Reset mid-burst:
  - The FSM goes to IDLE next cycle.
  - The Avalon command drops immediately.
  - Beats still arriving afterwards are discarded.
  - No done pulse is produced.
- The beat counter is LEN_W+1 bits and is cleared on every grant.

## Configuration
- Macro: `FB_ARB_STARVE_GUARD_EN`.
- Defined:
  - A starvation counter increments each cycle `p1_req` is high without grant, saturating at `STARVE_MAX`.
  - At `STARVE_MAX`, the next IDLE arbitration grants port 1 even if `p0_req` is high.
  - The counter clears on `p1_grant`.
- Undefined: strict port-0 priority; no counter logic is present.

## Test plan
- Port-0 read, addr 0x1000, len 3, slave latency 2, `waitrequest` high 2 cycles:
  - `av_read` is held 3 cycles with burstcount 4.
  - 4 `p0_rvalid` are seen with matching data.
  - `p0_done` arrives on beat 4.
- Port-1 write, len 7, data 0xA000..0xA007, `waitrequest` toggling every other cycle:
  - exactly 8 `p1_wready` pulses;
  - the slave receives 0xA000..0xA007 in order;
  - `p1_done` after the 8th accept.
- Both ports request in the same cycle: `p0_grant` first; `p1_grant` in the IDLE cycle after `p0_done`.
- With `FB_ARB_STARVE_GUARD_EN` defined, `STARVE_MAX` = 8, and `p0_req` held continuously with len 0: `p1_grant` fires once `p1_req` has waited ≥8 cycles.
- Without `FB_ARB_STARVE_GUARD_EN`: port 1 is never granted under the same stimulus.
- `reset` asserted on read beat 2 of 4:
  - all outputs are 0 the next cycle;
  - the remaining `av_readdatavalid` beats produce no rvalid;
  - a fresh port-0 burst then completes normally.
